// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore control FSM for the multicycle MIPS datapath. Optional
//            macro ILLEGAL_TRAP_EN traps unsupported instructions into HALT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_we,
  output logic       pc_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_RSVD      = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_t state_q, state_d;
  state_t dec_target;
  logic   dec_legal;

  // Instruction classification used by DECODE.
  always_comb begin
    dec_target = S_FETCH;
    dec_legal  = 1'b1;
    case (opcode)
      OP_LW, OP_SW:     dec_target = S_MEM_ADDR;
      OP_ADDI, OP_XORI: dec_target = S_I_EXEC;
      OP_BNE:           dec_target = S_BRANCH;
      OP_J:             dec_target = S_JUMP;
      OP_JAL:           dec_target = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: dec_target = S_R_EXEC;
          FN_JR:                  dec_target = S_JR;
          default:                dec_legal  = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_legal) begin
          state_d = dec_target;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && !dec_legal) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q & ~reset;
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

  // Outputs are a function of state only (pc_we in BRANCH and the NOP pulse
  // in DECODE excepted); reset overrides everything combinationally.
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
          instr_done = ~dec_legal;
`endif
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: iord = 1'b1;
        S_MEM_WB: begin
          reg_we     = 1'b1;
          wd_sel     = 2'b01;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          iord       = 1'b1;
          mem_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          case (funct)
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
        end
        S_R_WB: begin
          reg_we     = 1'b1;
          reg_dst    = 2'b01;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          if (opcode == OP_XORI) begin
            alu_src_b = 2'b11;
            alu_op    = ALU_XOR;
          end else begin
            alu_src_b = 2'b10;
          end
        end
        S_I_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = 2'b01;
          pc_we      = ~zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_we      = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        S_JAL: begin
          reg_we     = 1'b1;
          reg_dst    = 2'b10;
          wd_sel     = 2'b10;
          pc_we      = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_we      = 1'b1;
          pc_src     = 2'b11;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
